// File: rtl/seq1011_ctrl.sv
// seq1011_ctrl: word-level controller around an overlapping 1011 Mealy detector.
// A word accepted over in_valid/in_ready is shifted MSB-first through the
// detector, one bit per tick. The number of hits in that word is returned
// over out_valid/out_ready.
module seq1011_ctrl #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] match_cnt,
  output logic          hit,
  output logic          busy,
  output logic          flag
);

  localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} ctrl_e;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_e;

  ctrl_e          r_state, w_state_nxt;
  det_e           r_det, w_det_nxt, w_det_adv;
  logic [DW-1:0]  r_sr, w_sr_nxt;
  logic [BCW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [CW-1:0]  r_match_cnt, w_match_cnt_nxt;
  logic           r_flag, w_flag_nxt;

  logic w_x;
  logic w_step;
  logic w_hit;

  // Current bit and whether this edge consumes it.
  assign w_x    = r_sr[DW-1];
  assign w_step = (r_state == SHIFT) && tick;
  assign w_hit  = w_step && (r_det == S3) && w_x;

  // Detector transition for the current bit; the caller decides if it is used.
  always_comb begin
    w_det_adv = S0;
    unique case (r_det)
      S0: w_det_adv = w_x ? S1 : S0;
      S1: w_det_adv = w_x ? S1 : S2;
      S2: w_det_adv = w_x ? S3 : S0;
      S3: w_det_adv = w_x ? S1 : S2;
      default: w_det_adv = S0;
    endcase
  end

  // Controller next-state, datapath next values and handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_det_nxt       = r_det;
    w_sr_nxt        = r_sr;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_match_cnt_nxt = r_match_cnt;
    w_flag_nxt      = r_flag | w_hit;
    in_ready        = 1'b0;
    busy            = 1'b0;
    out_valid       = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Reset is synchronous, so mask ready while it is held.
        in_ready = ~rst;
        if (in_valid) begin
          w_state_nxt     = SHIFT;
          w_sr_nxt        = din;
          w_bit_cnt_nxt   = '0;
          w_match_cnt_nxt = '0;
          w_det_nxt       = S0;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (tick) begin
          w_det_nxt     = w_det_adv;
          w_sr_nxt      = r_sr << 1;
          w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          if (w_hit && (r_match_cnt != CNT_MAX)) begin
            w_match_cnt_nxt = r_match_cnt + CW'(1);
          end
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = REPORT;
          end
        end
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    if (rst) begin
      r_state     <= IDLE;
      r_det       <= S0;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_match_cnt <= '0;
      r_flag      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_det       <= w_det_nxt;
      r_sr        <= w_sr_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_flag      <= w_flag_nxt;
    end
  end

  assign match_cnt = r_match_cnt;
  assign hit       = w_hit;
  assign flag      = r_flag;

endmodule

// File: tb/tb_seq1011_ctrl.sv
// Directed bench for seq1011_ctrl. A second instance with a 1-bit count
// exercises saturation. Expected counts come from a window-scan model and
// are queued at accept time, then popped when the result is offered.
module tb_seq1011_ctrl;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, tick, in_valid, out_ready;
  logic [DW-1:0] din;
  logic          in_ready, out_valid, hit, busy, flag;
  logic [CW-1:0] match_cnt;
  logic          in_ready_s, out_valid_s, hit_s, busy_s, flag_s;
  logic [0:0]    match_cnt_s;

  int total = 0;
  int bad   = 0;
  int sb_q[$];
  int sbs_q[$];
  int word_hits, word_hits_s;
  bit exp_flag;

  seq1011_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .match_cnt(match_cnt),
    .hit(hit), .busy(busy), .flag(flag)
  );

  seq1011_ctrl #(.DW(DW), .CW(1)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_ready(in_ready_s),
    .din(din), .out_valid(out_valid_s), .out_ready(out_ready), .match_cnt(match_cnt_s),
    .hit(hit_s), .busy(busy_s), .flag(flag_s)
  );

  always #5 clk = ~clk;

  // Count overlapping 1011 windows, MSB first.
  function automatic int ref_count(input logic [DW-1:0] w);
    int n = 0;
    for (int i = DW - 1; i >= 3; i--) begin
      if (w[i -: 4] == 4'b1011) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample combinational outputs mid-cycle, then return 1 ns after the edge.
  task automatic cyc();
    @(negedge clk);
    if (hit === 1'b1)   word_hits++;
    if (hit_s === 1'b1) word_hits_s++;
    chk("ready_valid_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
    chk("hit_only_in_shift", {31'd0, hit & ~busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_flag"}, {31'd0, flag}, 32'd0);
    chk({tag, "_match_cnt"}, {28'd0, match_cnt}, 32'd0);
    chk({tag, "_hit"}, {31'd0, hit}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; tick = 1'b0; out_ready = 1'b0; din = '0;
    cyc();
    cyc();
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    check_reset_values("rst");
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    sbs_q.delete();
    exp_flag = 1'b0;
  endtask

  // Send one word, run it to REPORT, optionally hold off out_ready, then drain.
  task automatic send_word(input logic [DW-1:0] word, input int tick_every,
                           input int hold, input bit noisy);
    int k;
    int exp_n;
    int exp_cnt, exp_sat;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    exp_n = ref_count(word);
    sb_q.push_back(exp_n);
    sbs_q.push_back(exp_n > 1 ? 1 : exp_n);
    din = word; in_valid = 1'b1; tick = 1'b1; out_ready = (hold == 0);
    word_hits = 0; word_hits_s = 0;
    cyc();
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("sat_busy", {31'd0, busy_s}, 32'd1);
    in_valid = noisy;
    din = ~word;
    k = 0;
    while (out_valid !== 1'b1 && k < 400) begin
      k++;
      tick = ((k % tick_every) == 0);
      cyc();
    end
    tick = 1'b1;
    chk("report_latency", k, DW * tick_every);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("sat_out_valid", {31'd0, out_valid_s}, 32'd1);
    exp_cnt = 0; exp_sat = 0;
    if (sb_q.size() == 0 || sbs_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_cnt = sb_q.pop_front();
      exp_sat = sbs_q.pop_front();
      chk("match_cnt", {28'd0, match_cnt}, exp_cnt);
      chk("sat_match_cnt", {31'd0, match_cnt_s}, exp_sat);
    end
    chk("hit_pulses", word_hits, exp_n);
    chk("sat_hit_pulses", word_hits_s, exp_n);
    if (exp_n > 0) exp_flag = 1'b1;
    chk("flag", {31'd0, flag}, {31'd0, exp_flag});
    chk("sat_flag", {31'd0, flag_s}, {31'd0, exp_flag});
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_match_cnt", {28'd0, match_cnt}, exp_cnt);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    chk("sat_drain_in_ready", {31'd0, in_ready_s}, 32'd1);
    chk("drain_match_cnt_held", {28'd0, match_cnt}, exp_cnt);
    out_ready = 1'b0;
  endtask

  initial begin
    do_reset();

    // Basic word: two overlapping hits, flag set.
    send_word(8'b1011_0110, 1, 0, 1'b0);

    // No hits, then one hit; flag only rises on the second word.
    do_reset();
    send_word(8'hFF, 1, 0, 1'b0);
    send_word(8'b0001_0110, 1, 0, 1'b0);

    // A partial match at the end of one word must not complete in the next.
    do_reset();
    send_word(8'b0000_0101, 1, 0, 1'b0);
    send_word(8'b1000_0000, 1, 0, 1'b0);

    // Slow tick: one bit every fourth cycle.
    send_word(8'b1011_0110, 4, 0, 1'b0);

    // Backpressure with in_valid and din toggling outside IDLE.
    send_word(8'b0110_1101, 1, 5, 1'b1);

    // Reset in the middle of a word.
    din = 8'b1011_1011; in_valid = 1'b1; tick = 1'b1; out_ready = 1'b1;
    sb_q.push_back(ref_count(din));
    word_hits = 0;
    cyc();
    in_valid = 1'b0;
    din = '0;
    repeat (4) cyc();
    chk("midrst_hit_seen", word_hits, 1);
    chk("midrst_flag_set", {31'd0, flag}, 32'd1);
    rst = 1'b1;
    cyc();
    chk("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
    check_reset_values("midrst");
    rst = 1'b0;
    sb_q.delete();
    sbs_q.delete();
    exp_flag = 1'b0;
    #1;
    chk("midrst_idle", {31'd0, in_ready}, 32'd1);
    send_word(8'b1011_1011, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq1011_ctrl.md
# seq1011_ctrl

Word-level controller for the 1011 overlapping Mealy sequence detector. It accepts parallel words over a valid/ready handshake and shifts each word MSB-first through an embedded detector, one bit per enabled cycle. It counts the detector hits per word and returns the count over a second valid/ready handshake. It sits between a word source (switches, a FIFO or a test driver) and a display/result sink, replacing free-running load/shift control with explicit sequencing.

## Interface
- DW, 8, word width in bits, ≥1
- CW, 4, width of match_cnt; the count saturates at 2^CW-1
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  bit-step enable; one bit is consumed per clk edge with tick=1 (tie high for full rate; drive from a divider strobe for board visualisation)
- in_valid  in  1  din holds a word to process
- in_ready  out  1  controller can accept a word
- din  in  DW  parallel input word; bit DW-1 is shifted first
- out_valid  out  1  match_cnt holds a finished result
- out_ready  in  1  sink accepts the result
- match_cnt  out  CW  number of 1011 hits in the last word, overlapping
- hit  out  1  Mealy output: current bit completes 1011 (combinational)
- busy  out  1  a word is being shifted
- flag  out  1  sticky; set on the first hit after reset

## Operation
- Controller FSM states:
  - IDLE: in_ready=1.
  - SHIFT: busy=1.
  - REPORT: out_valid=1.
- IDLE → SHIFT on in_valid&in_ready at an edge. On that edge:
  - shift register ← din
  - bit counter ← 0
  - match_cnt ← 0
  - detector state ← S0
- SHIFT, edge with tick=1:
  - Current bit is x = sr[DW-1].
  - Detector advances; sr shifts left with 0 fill; bit counter increments.
  - If hit, match_cnt increments, saturating at 2^CW-1.
- SHIFT, edge with tick=0: nothing changes.
- SHIFT → REPORT on the edge that consumes bit DW-1.
- REPORT → IDLE on out_ready=1. match_cnt holds its value until the next word is accepted.
- Detector, overlapping, x = current bit:
  - S0: x=1 → S1, else S0.
  - S1: x=1 → S1, else S2.
  - S2: x=1 → S3, else S0.
  - S3: x=1 → S1 with hit, else S2.
- hit = (state==SHIFT) & tick & (det==S3) & x. hit is never asserted outside SHIFT.
- The detector is cleared per word. No match spans two words.
- flag is set on any edge where hit=1. Only rst clears it.
- With DW<4, match_cnt is always 0.

## Timing
- Reset values:
  - FSM = IDLE, detector = S0.
  - sr, bit counter, match_cnt = 0.
  - flag, out_valid, busy, hit = 0.
  - in_ready = 0 while rst=1; in_ready = 1 in the first cycle after rst deasserts.
- Latency with tick held high:
  - Word accepted at edge A.
  - Bits are consumed at edges A+1 … A+DW.
  - out_valid is high from edge A+DW.
  - Best-case throughput is one word per DW+2 cycles (the REPORT cycle, then the IDLE cycle).
- in_ready and out_valid are never high together. There is no accept-while-reporting bypass.
- in_valid is ignored outside IDLE. din is sampled only on the accepting edge.
- out_valid stays high and match_cnt stays stable until out_ready is seen. Backpressure holds indefinitely.
- Reset mid-SHIFT or mid-REPORT discards the word and result; the block returns to the reset values on that edge.
- Saturation: once match_cnt = 2^CW-1, further hits still pulse hit and set flag, but the count does not change.

## Test plan
- Reset release, then din=8'b1011_0110, in_valid for one cycle, tick=1, out_ready=1 → in_ready drops at edge A; hit pulses on bits 3 and 6; out_valid at A+8 with match_cnt=2; flag=1.
- din=8'hFF, then 8'b0001_0110 → match_cnt=0, then 1; flag stays 0 after the first word and is set during the second.
- Cross-word isolation: 8'b0000_0101 then 8'b1000_0000 → match_cnt=0 for both; flag=0.
- tick asserted one cycle in four, din=8'b1011_0110 → state frozen on tick=0 edges; out_valid 32 cycles after accept; match_cnt=2.
- out_ready held low for 5 cycles in REPORT → out_valid=1, match_cnt constant, in_ready=0 throughout; IDLE the edge after out_ready rises.
- rst pulse after 4 bits of 8'b1011_1011 → hit already pulsed and flag=1; after reset, flag=0, match_cnt=0, FSM IDLE, no out_valid; the next word 8'b1011_1011 gives match_cnt=2.
